// File: rtl/rtdf_pkg.sv
// Shared types and constants for the RTDF frame parser.
// Holds the FSM state encoding, header geometry, minimum frame length and default EtherType.
// No logic; imported by every RTL file of the parser.
package rtdf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_TYPE    = 3'd2,
        ST_SEQ     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_DRAIN   = 3'd5
    } rtdf_state_e;

    typedef logic [15:0] rtdf_word_t;

    // Words between the length word and the sequence word: 3 dst MAC + 3 src MAC + EtherType.
    localparam int RTDF_HDR_WORDS = 7;

    // Smallest legal frame in bytes: length, 7 header words, sequence and one payload word.
    localparam int RTDF_MIN_LEN = 20;

    localparam rtdf_word_t RTDF_DEFAULT_ETHERTYPE = 16'h88B5;

endpackage

// File: rtl/rtdf_out_reg.sv
// Single-entry output register for payload words, with the accept decision feeding the pop logic.
// Latency: 1 clk from load (in_vld) to out_valid; sustains 1 word/clk while out_ready=1.
// Backpressure: out_valid=1 with out_ready=0 holds out_data and deasserts can_accept.
// Ports: clk/reset_n, in_vld/in_dat (load strobe + word), out_ready (downstream accept),
//        can_accept (register can take a word this cycle), out_valid/out_data.
module rtdf_out_reg
    import rtdf_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_vld,
    input  rtdf_word_t in_dat,
    input  logic       out_ready,
    output logic       can_accept,
    output logic       out_valid,
    output rtdf_word_t out_data
);

    logic       valid_q, valid_d;
    rtdf_word_t data_q, data_d;

    // out_ready is only meaningful while a word is held, so an empty register always accepts.
    assign can_accept = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_vld) begin
            valid_d = 1'b1;
            data_d  = in_dat;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/rtdf_frame_parser.sv
// Parses RTDF sample frames from a show-ahead RX FIFO and forwards payload words of matching EtherType.
// Latency: 1 clk from payload pop to out_valid; full 1 word/clk throughput.
// Backpressure: payload pops stop while the output register is full and out_ready=0; FIFO empty stalls all states.
// Ports: clk/reset_n, rx_fifo_rd_data/rx_fifo_empty/rx_fifo_rd_req (FIFO read side),
//        out_data/out_valid/out_ready (sample output), packet_count/good_packet_count/seq_error_count (9b wrap).
// Optional feature: define RTDF_SEQ_CHECK_EN to enable sequence-continuity checking (seq_error_count).
module rtdf_frame_parser
    import rtdf_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = RTDF_DEFAULT_ETHERTYPE,
    parameter logic [10:0] MAX_WORDS = 11'd730
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] rx_fifo_rd_data,
    input  logic        rx_fifo_empty,
    output logic        rx_fifo_rd_req,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  packet_count,
    output logic [8:0]  good_packet_count,
    output logic [8:0]  seq_error_count
);

    rtdf_state_e state_q, state_d;
    logic [15:0] rem_q, rem_d;          // words of the current frame still to pop after word0
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;  // MAC words popped so far in HDR
    logic [8:0]  pkt_cnt_q, pkt_cnt_d;
    logic [8:0]  good_cnt_q, good_cnt_d;

    logic pop;
    logic pay_pop;
    logic out_can_accept;
    logic len_ok;
    logic last_word;

    // L counts bytes including the length word; 18 bytes are length + 7 header words + sequence.
    assign len_ok = !rx_fifo_rd_data[0]
                 && (rx_fifo_rd_data >= 16'(RTDF_MIN_LEN))
                 && (((rx_fifo_rd_data - 16'd18) >> 1) <= {5'd0, MAX_WORDS});

    assign last_word = (rem_q == 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transition is qualified by a pop, so an empty FIFO freezes the FSM.
    always_comb begin
        state_d = state_q;
        if (pop) begin
            unique case (state_q)
                ST_IDLE:    state_d = len_ok ? ST_HDR : ST_IDLE;
                ST_HDR:     if (hdr_cnt_q == 3'(RTDF_HDR_WORDS - 2)) state_d = ST_TYPE;
                ST_TYPE:    state_d = (rx_fifo_rd_data == ETHERTYPE) ? ST_SEQ : ST_DRAIN;
                ST_SEQ:     state_d = ST_PAYLOAD;
                ST_PAYLOAD: if (last_word) state_d = ST_IDLE;
                ST_DRAIN:   if (last_word) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: pop requests, gated by reset so nothing leaves the FIFO while reset_n=0.
    always_comb begin
        rx_fifo_rd_req = 1'b0;
        pay_pop        = 1'b0;
        if (reset_n && !rx_fifo_empty) begin
            if (state_q == ST_PAYLOAD) begin
                rx_fifo_rd_req = out_can_accept;
                pay_pop        = out_can_accept;
            end else begin
                rx_fifo_rd_req = 1'b1;
            end
        end
    end

    assign pop = rx_fifo_rd_req;

    // Frame bookkeeping counters
    always_comb begin
        rem_d      = rem_q;
        hdr_cnt_d  = hdr_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        good_cnt_d = good_cnt_q;
        if (pop) begin
            if (state_q == ST_IDLE) begin
                pkt_cnt_d = pkt_cnt_q + 9'd1;
                rem_d     = (rx_fifo_rd_data - 16'd1) >> 1;  // ceil((L-2)/2)
                hdr_cnt_d = '0;
            end else begin
                rem_d = rem_q - 16'd1;
                if (state_q == ST_HDR) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                end
                if (state_q == ST_PAYLOAD && last_word) begin
                    good_cnt_d = good_cnt_q + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q      <= '0;
            hdr_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            good_cnt_q <= '0;
        end else begin
            rem_q      <= rem_d;
            hdr_cnt_q  <= hdr_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            good_cnt_q <= good_cnt_d;
        end
    end

`ifdef RTDF_SEQ_CHECK_EN
    // The latched sequence number doubles as "previous" for the next frame's continuity check.
    logic [15:0] seq_q, seq_d;
    logic        seq_seen_q, seq_seen_d;  // suppresses the check on the first frame after reset
    logic [8:0]  seq_err_q, seq_err_d;

    always_comb begin
        seq_d      = seq_q;
        seq_seen_d = seq_seen_q;
        seq_err_d  = seq_err_q;
        if (pop && state_q == ST_SEQ) begin
            seq_d      = rx_fifo_rd_data;
            seq_seen_d = 1'b1;
            if (seq_seen_q && (rx_fifo_rd_data != 16'(seq_q + 16'd1))) begin
                seq_err_d = seq_err_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_q      <= '0;
            seq_seen_q <= 1'b0;
            seq_err_q  <= '0;
        end else begin
            seq_q      <= seq_d;
            seq_seen_q <= seq_seen_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign seq_error_count = seq_err_q;
`else
    // The sequence word is popped and discarded; nothing consumes it without the checker.
    assign seq_error_count = '0;
`endif

    rtdf_out_reg u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vld     (pay_pop),
        .in_dat     (rx_fifo_rd_data),
        .out_ready  (out_ready),
        .can_accept (out_can_accept),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    assign packet_count      = pkt_cnt_q;
    assign good_packet_count = good_cnt_q;

endmodule

// File: tb/tb_rtdf_frame_parser.sv
// Testbench for rtdf_frame_parser: FIFO model feeding word streams, frame-level reference model,
// directed and randomized scenarios with per-scenario reset.
module tb_rtdf_frame_parser;

    localparam logic [15:0] ET   = 16'h88B5;
    localparam int          MAXW = 730;

    typedef logic [15:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] rx_fifo_rd_data = 16'h0;
    logic        rx_fifo_empty = 1'b1;
    logic        rx_fifo_rd_req;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  packet_count;
    logic [8:0]  good_packet_count;
    logic [8:0]  seq_error_count;

    rtdf_frame_parser dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_fifo_rd_data   (rx_fifo_rd_data),
        .rx_fifo_empty     (rx_fifo_empty),
        .rx_fifo_rd_req    (rx_fifo_rd_req),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .packet_count      (packet_count),
        .good_packet_count (good_packet_count),
        .seq_error_count   (seq_error_count)
    );

    always #5 clk = ~clk;

    word_q_t     stream, fifo, got;
    int          got_cyc[$];
    int          cyc = 0, pops = 0, checks = 0, errors = 0;
    int          ready_mode = 0, ridx = 0;
    bit          gap_en = 0, saw_valid = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [15:0] rseq = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_fifo_empty   = (fifo.size() == 0) || (gap_en && $urandom_range(3) == 0);
        rx_fifo_rd_data = (fifo.size() > 0) ? fifo[0] : 16'h0;
    endtask

    // One clock: observe at negedge, apply FIFO pop and new inputs 1 time unit after posedge.
    task automatic cycle();
        bit         do_pop;
        logic [3:0] pat;
        pat = 4'b1001;
        @(negedge clk);
        cyc++;
        do_pop = 0;
        if (rx_fifo_rd_req) begin
            chk("pop_while_empty", {31'd0, rx_fifo_empty}, 32'd0);
            do_pop = !rx_fifo_empty;
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        end
        if (out_valid) saw_valid = 1;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        if (do_pop && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        refresh_rx();
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = pat[ridx]; ridx = (ridx + 1) % 4; end
            default: out_ready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic add_frame(input int len, input logic [15:0] et, input logic [15:0] sq, input bit body);
        stream.push_back(16'(len));
        if (body) begin
            for (int k = 0; k < 6; k++) stream.push_back(16'($urandom));
            stream.push_back(et);
            stream.push_back(sq);
            for (int k = 0; k < (len - 18) / 2; k++) stream.push_back(16'($urandom));
        end
    endtask

    // Frame-level reference: walks the byte-length framing and applies the acceptance rules.
    task automatic model(input word_q_t s, output word_q_t pay, output int pkt, output int good, output int serr);
        int          i, l, n;
        bit          seen;
        logic [15:0] prev;
        pay = {}; pkt = 0; good = 0; serr = 0; i = 0; seen = 0; prev = 0;
        while (i < s.size()) begin
            l = int'(s[i]);
            pkt++;
            if ((l % 2) != 0 || l < 20 || (l - 18) / 2 > MAXW) begin
                i++;
            end else begin
                n = (l - 2) / 2;
                if (s[i + 7] == ET) begin
                    good++;
                    if (seen && s[i + 8] != 16'(prev + 16'd1)) serr++;
                    seen = 1;
                    prev = s[i + 8];
                    for (int k = 9; k <= n; k++) pay.push_back(s[i + k]);
                end
                i += n + 1;
            end
        end
    endtask

    task automatic start_scn(input string tag);
        fifo = stream; got = {}; got_cyc = {}; pops = 0; ridx = 0;
        prev_stall = 0; saw_valid = 0; gap_en = 0; ready_mode = 0;
        refresh_rx();
        reset_n = 1'b0;
        repeat (3) cycle();
        chk({tag, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rst_pkt"}, {23'd0, packet_count}, 32'd0);
        chk({tag, "_rst_good"}, {23'd0, good_packet_count}, 32'd0);
        chk({tag, "_rst_seq"}, {23'd0, seq_error_count}, 32'd0);
        chk({tag, "_rst_rdreq"}, {31'd0, rx_fifo_rd_req}, 32'd0);
        reset_n = 1'b1;
        saw_valid = 0;
    endtask

    task automatic finish_scn(input string tag);
        word_q_t ep;
        int      pk, gd, se, n;
        model(stream, ep, pk, gd, se);
        n = 0;
        while (!(fifo.size() == 0 && !out_valid) && n < 20000) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, {31'd0, (n < 20000)}, 32'd1);
        repeat (3) cycle();
        chk({tag, "_paylen"}, got.size(), ep.size());
        for (int k = 0; k < ep.size() && k < got.size(); k++)
            chk($sformatf("%s_pay%0d", tag, k), {16'd0, got[k]}, {16'd0, ep[k]});
        chk({tag, "_pkt"}, {23'd0, packet_count}, pk % 512);
        chk({tag, "_good"}, {23'd0, good_packet_count}, gd % 512);
`ifdef RTDF_SEQ_CHECK_EN
        chk({tag, "_seqerr"}, {23'd0, seq_error_count}, se % 512);
`else
        chk({tag, "_seqerr"}, {23'd0, seq_error_count}, 32'd0);
`endif
        chk({tag, "_pops"}, pops, stream.size());
    endtask

    initial begin
        // Basic frame L=24, three payload words, out_ready held high
        stream = {};
        add_frame(24, ET, 16'd1, 1);
        start_scn("basic");
        finish_scn("basic");
        chk("basic_consec", (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[0] : -1, 2);

        // Wrong EtherType: whole frame drained, nothing forwarded
        stream = {};
        add_frame(24, 16'h0800, 16'd1, 1);
        start_scn("drain");
        finish_scn("drain");
        chk("drain_no_valid", {31'd0, saw_valid}, 32'd0);

        // Odd length followed by a valid frame
        stream = {};
        add_frame(23, ET, 16'd0, 0);
        add_frame(26, ET, 16'd7, 1);
        start_scn("oddlen");
        finish_scn("oddlen");

        // Backpressure pattern 1,0,0,1
        stream = {};
        add_frame(36, ET, 16'd3, 1);
        add_frame(22, ET, 16'd4, 1);
        start_scn("bp");
        ready_mode = 1;
        finish_scn("bp");

        // Length boundaries: minimum, too short, maximum, one past maximum
        stream = {};
        add_frame(20, ET, 16'd10, 1);
        add_frame(18, ET, 16'd0, 0);
        add_frame(18 + 2 * MAXW, ET, 16'd11, 1);
        add_frame(20 + 2 * MAXW, ET, 16'd0, 0);
        add_frame(22, ET, 16'd12, 1);
        start_scn("bound");
        finish_scn("bound");

        // Sequence continuity 5,6,8, then a fresh run FFFF,0000
        stream = {};
        add_frame(22, ET, 16'd5, 1);
        add_frame(22, ET, 16'd6, 1);
        add_frame(22, ET, 16'd8, 1);
        start_scn("seq568");
        finish_scn("seq568");
        stream = {};
        add_frame(22, ET, 16'hFFFF, 1);
        add_frame(22, ET, 16'h0000, 1);
        start_scn("seqwrap");
        finish_scn("seqwrap");

        // Reset in the middle of PAYLOAD, then a fresh frame
        stream = {};
        add_frame(60, ET, 16'd20, 1);
        start_scn("midrst");
        begin
            int n;
            n = 0;
            while (got.size() < 3 && n < 200) begin
                cycle();
                n++;
            end
            chk("midrst_reached", {31'd0, (got.size() >= 3)}, 32'd1);
        end
        reset_n = 1'b0;
        repeat (3) cycle();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_pkt", {23'd0, packet_count}, 32'd0);
        chk("midrst_good", {23'd0, good_packet_count}, 32'd0);
        chk("midrst_rdreq", {31'd0, rx_fifo_rd_req}, 32'd0);
        stream = {};
        add_frame(26, ET, 16'd40, 1);
        fifo = stream; got = {}; got_cyc = {}; pops = 0; prev_stall = 0;
        refresh_rx();
        reset_n = 1'b1;
        finish_scn("midrst_fresh");

        // Randomized mix: lengths, EtherTypes, sequence gaps, FIFO gaps and random out_ready
        stream = {};
        rseq = 16'($urandom);
        for (int f = 0; f < 40; f++) begin
            int sel, len;
            sel = $urandom_range(9);
            if (sel == 0) begin
                len = ($urandom_range(2) == 0) ? 2 * $urandom_range(9) + 1
                    : (($urandom_range(1) == 0) ? 2 * $urandom_range(9) : 20 + 2 * MAXW + 2 * $urandom_range(5));
                add_frame(len, ET, 16'd0, 0);
            end else begin
                len = 20 + 2 * $urandom_range(12);
                rseq = ($urandom_range(4) == 0) ? 16'($urandom) : 16'(rseq + 16'd1);
                add_frame(len, ($urandom_range(3) == 0) ? 16'($urandom) : ET, rseq, 1);
            end
        end
        start_scn("rand");
        ready_mode = 2;
        gap_en = 1;
        finish_scn("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtdf_frame_parser.md
RTDF_FRAME_PARSER -- requirements
Module: rtdf_frame_parser

Interface
REQ-001 Parameter ETHERTYPE, default 16'h88B5, is the accepted EtherType for sample frames.
REQ-002 Parameter MAX_WORDS, default 11'd730, is the maximum number of payload sample words per frame.
REQ-003 clk  in  1  Single clock; all logic is rising-edge, and no other clock exists in the block.
REQ-004 reset_n  in  1  Reset is synchronous and active-low.
REQ-005 rx_fifo_rd_data  in  16  Show-ahead RX FIFO head word; it is valid whenever rx_fifo_empty=0.
REQ-006 rx_fifo_empty  in  1  RX FIFO empty flag.
REQ-007 rx_fifo_rd_req  out  1  Pops the FIFO head this cycle; it is combinational and never asserted while rx_fifo_empty=1.
REQ-008 out_data  out  16  Payload sample word, with 5x3b samples in LSB-first order plus 1 spare bit.
REQ-009 out_valid  out  1  out_data holds a word.
REQ-010 out_ready  in  1  Downstream sample-FIFO write enable; it is valid only when out_valid=1.
REQ-011 packet_count  out  9  Frames whose length word has been read.
REQ-012 good_packet_count  out  9  Frames whose payload was forwarded.
REQ-013 seq_error_count  out  9  Sequence discontinuities (RTDF_SEQ_CHECK_EN only; otherwise tied to 0).

Function
REQ-014 The block SHALL interpret each frame as the following stream: word0 = frame byte length L; 3 words destination MAC; 3 words source MAC; 1 word EtherType; 1 word sequence number; then (L-18)/2 payload words.
REQ-015 The FSM SHALL have the states IDLE, HDR, TYPE, SEQ, PAYLOAD and DRAIN.
REQ-016 IDLE SHALL behave as follows: when the FIFO is not empty, pop the length word, increment packet_count, load the remaining-word counter with ceil((L-2)/2), and go to HDR.
REQ-017 A length word SHALL be invalid if L is odd, L<20, or (L-18)/2>MAX_WORDS; an invalid length SHALL cause the block to return to IDLE after popping only word0.
REQ-018 HDR SHALL pop 6 words, discarding them, and then go to TYPE.
REQ-019 TYPE SHALL pop 1 word; if the word equals ETHERTYPE the FSM goes to SEQ, otherwise it goes to DRAIN.
REQ-020 SEQ SHALL pop 1 word, latch it as the current sequence number, and go to PAYLOAD.
REQ-021 PAYLOAD SHALL forward each word, pop it only when the output register accepts it, and go to IDLE after the last payload word.
REQ-022 The good_packet_count counter SHALL increment on the cycle the last payload word is popped.
REQ-023 DRAIN SHALL pop the remaining words and go to IDLE when the counter reaches 0.
REQ-024 The output register SHALL load on the pop cycle when out_valid=0 or out_ready=1, giving a latency of 1 clk from pop to out_valid.
REQ-025 The output register SHALL allow full throughput of 1 word per clk while out_ready=1.
REQ-026 When out_valid=1 and out_ready=0, out_data SHALL hold its value and no PAYLOAD pop SHALL occur.
REQ-027 While rx_fifo_empty=1 in any state, the FSM SHALL stall with no counter change.
REQ-028 All counters SHALL be 9b and wrap from 511 to 0.
REQ-029 The forwarding decision SHALL be complete before the first payload word, so no partial frame is ever emitted.

Reset
REQ-030 When reset_n=0 at a clk edge, the FSM SHALL go to IDLE and out_valid, all counters, and the latched sequence number SHALL become 0.
REQ-031 rx_fifo_rd_req SHALL be 0 during reset.
REQ-032 A reset in the middle of a frame SHALL abandon that frame, and the block SHALL treat the next FIFO word after release as a length word.

Configuration
REQ-033 With RTDF_SEQ_CHECK_EN defined, SEQ SHALL compare the incoming sequence number with the previous one plus 1 (16b wrap) and increment seq_error_count on mismatch; the frame is still forwarded.
REQ-034 With RTDF_SEQ_CHECK_EN defined, the first frame after reset SHALL never count as an error.
REQ-035 Without RTDF_SEQ_CHECK_EN, no comparator or previous-sequence register SHALL exist, and seq_error_count SHALL be 0.

Structure
REQ-036 The rtdf_pkg package SHALL hold the FSM state encoding, the header word count (7), the minimum length (20), and the default ETHERTYPE.
REQ-037 The output register and accept logic SHALL be the sub-module rtdf_out_reg; all other logic SHALL be flat.

Verification
REQ-038 Send L=24 (3 payload words A,B,C), EtherType 88B5, with out_ready=1 -> out_data is A,B,C on consecutive cycles, and packet_count=1, good_packet_count=1.
REQ-039 Send the same frame with EtherType 0800 -> no out_valid, all 12 words popped, packet_count=1, good_packet_count=0.
REQ-040 Send L=23, then a valid frame -> only word0 of the first frame is popped, and the second frame is forwarded intact.
REQ-041 Send a valid frame with out_ready toggling 1,0,0,1 -> no word is lost or duplicated, and out_data is stable while stalled.
REQ-042 With RTDF_SEQ_CHECK_EN, send sequences 5,6,8 -> seq_error_count=1; send FFFF then 0000 -> no error.
REQ-043 Deassert then reassert reset_n in the middle of PAYLOAD, then send a fresh frame -> out_valid=0 and counters=0 during reset, and the fresh frame parses correctly.
